// File: rtl/regfile_write_arbiter_pkg.sv
// Shared types and constants for the register-file write arbiter: address/data
// widths, priority FSM encoding and a register-index decode helper.
package regfile_write_arbiter_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int DATA_W     = 32;
  localparam int NUM_REGS   = 32;

  typedef enum logic {
    PRI_ALU = 1'b0,
    PRI_MEM = 1'b1
  } pri_state_e;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;
  typedef logic [DATA_W-1:0]     reg_data_t;
  typedef logic [NUM_REGS-1:0]   reg_mask_t;

  // R0 is hardwired, so it never maps onto a scoreboard bit.
  function automatic reg_mask_t reg_onehot(input reg_addr_t addr);
    reg_mask_t m;
    m = '0;
    if (addr != '0) m[addr] = 1'b1;
    return m;
  endfunction

endpackage

// File: rtl/regfile_write_arbiter_if.sv
// Bundle of writeback requests, issue/hazard queries and the registered
// register-file write port shared between the arbiter and its environment.
interface regfile_write_arbiter_if;
  import regfile_write_arbiter_pkg::*;

  logic      alu_req;
  reg_addr_t alu_rd;
  reg_data_t alu_data;
  logic      alu_gnt;

  logic      mem_req;
  reg_addr_t mem_rd;
  reg_data_t mem_data;
  logic      mem_gnt;

  logic      issue_valid;
  reg_addr_t issue_rd;

  reg_addr_t read_reg1;
  reg_addr_t read_reg2;
  logic      stall;

  logic      RegWrite;
  reg_addr_t write_reg;
  reg_data_t write_data;
  reg_mask_t pending;

  modport master (
    output alu_req, alu_rd, alu_data,
    output mem_req, mem_rd, mem_data,
    output issue_valid, issue_rd,
    output read_reg1, read_reg2,
    input  alu_gnt, mem_gnt, stall,
    input  RegWrite, write_reg, write_data, pending
  );

  modport slave (
    input  alu_req, alu_rd, alu_data,
    input  mem_req, mem_rd, mem_data,
    input  issue_valid, issue_rd,
    input  read_reg1, read_reg2,
    output alu_gnt, mem_gnt, stall,
    output RegWrite, write_reg, write_data, pending
  );

endinterface

// File: rtl/regfile_write_arbiter_rr_arbiter2.sv
// Two-way round-robin grant: a lone requester always wins, and on contention
// the favoured side wins and the favour passes to the other side.
module rr_arbiter2
  import regfile_write_arbiter_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,   // [0] = ALU, [1] = MEM
  output logic [1:0] gnt
);

  pri_state_e state_q;
  pri_state_e state_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= PRI_ALU;
    else        state_q <= state_d;
  end

  // Favour only moves when both sides collide; lone grants keep it put.
  always_comb begin
    state_d = state_q;
    if (&req) state_d = (state_q == PRI_ALU) ? PRI_MEM : PRI_ALU;
  end

  always_comb begin
    gnt = req;
    if (&req) gnt = (state_q == PRI_ALU) ? 2'b01 : 2'b10;
  end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Arbitrates ALU and load writebacks onto a single registered register-file
// write port and tracks outstanding destinations for RAW hazard detection.
module regfile_write_arbiter
  import regfile_write_arbiter_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  regfile_write_arbiter_if.slave bus
);

  function automatic logic hazard(input reg_addr_t addr, input reg_mask_t pend);
    return (addr != '0) && pend[addr];
  endfunction

  logic [1:0] req_p0;
  logic [1:0] gnt_p0;
  reg_addr_t  rd_p0;
  reg_data_t  data_p0;
  logic       vld_p0;

  logic       vld_p1;
  reg_addr_t  wr_rd_p1;
  reg_data_t  wr_data_p1;

  reg_mask_t  pending_q;
  reg_mask_t  pending_d;
  reg_mask_t  set_mask;
  reg_mask_t  clr_mask;

  // Requests are masked while reset is low so no grant escapes during reset.
  assign req_p0 = {bus.mem_req, bus.alu_req} & {2{reset}};

  rr_arbiter2 u_arb (
    .clk   (clk),
    .reset (reset),
    .req   (req_p0),
    .gnt   (gnt_p0)
  );

  assign bus.alu_gnt = gnt_p0[0];
  assign bus.mem_gnt = gnt_p0[1];

  always_comb begin
    rd_p0   = gnt_p0[1] ? bus.mem_rd   : bus.alu_rd;
    data_p0 = gnt_p0[1] ? bus.mem_data : bus.alu_data;
    vld_p0  = (|gnt_p0) && (rd_p0 != '0);
  end

  // Stage p0 -> p1: registered write port toward the register file.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vld_p1     <= 1'b0;
      wr_rd_p1   <= '0;
      wr_data_p1 <= '0;
    end else begin
      vld_p1 <= vld_p0;
      if (vld_p0) begin
        wr_rd_p1   <= rd_p0;
        wr_data_p1 <= data_p0;
      end
    end
  end

  assign bus.RegWrite   = vld_p1;
  assign bus.write_reg  = wr_rd_p1;
  assign bus.write_data = wr_data_p1;

  // Clear lands on the register-file capture edge; a same-edge issue re-sets.
  always_comb begin
    set_mask     = bus.issue_valid ? reg_onehot(bus.issue_rd) : '0;
    clr_mask     = vld_p1 ? reg_onehot(wr_rd_p1) : '0;
    pending_d    = (pending_q & ~clr_mask) | set_mask;
    pending_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) pending_q <= '0;
    else        pending_q <= pending_d;
  end

  assign bus.pending = pending_q;
  assign bus.stall   = hazard(bus.read_reg1, pending_q) | hazard(bus.read_reg2, pending_q);

endmodule
